// File: rtl/parallel_serializer.sv
// Parallel-to-serial transmitter with a one-word skid buffer.
// Emits one bit per bit_en_i strobe, with per-bit valid and end-of-word marker.
module parallel_serializer #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic             bit_en_i,
    output logic             x_o,
    output logic             x_valid_o,
    output logic             last_o,
    output logic             busy_o
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state_ff, state_nxt;
    logic [WIDTH-1:0] buf_ff, buf_nxt;
    logic             buf_vld_ff, buf_vld_nxt;
    logic [WIDTH-1:0] sh_ff, sh_nxt;
    logic [CW-1:0]    cnt_ff, cnt_nxt;

    logic accept;
    logic last_strobe;
    logic load;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_ff   <= IDLE;
            buf_ff     <= '0;
            buf_vld_ff <= 1'b0;
            sh_ff      <= '0;
            cnt_ff     <= '0;
        end else begin
            state_ff   <= state_nxt;
            buf_ff     <= buf_nxt;
            buf_vld_ff <= buf_vld_nxt;
            sh_ff      <= sh_nxt;
            cnt_ff     <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state_ff;
        buf_nxt     = buf_ff;
        buf_vld_nxt = buf_vld_ff;
        sh_nxt      = sh_ff;
        cnt_nxt     = cnt_ff;

        accept      = valid_i && !buf_vld_ff;
        last_strobe = (state_ff == SHIFT) && bit_en_i && (cnt_ff == CNT_LAST);
        load        = buf_vld_ff && ((state_ff == IDLE) || last_strobe);

        // accept and load are mutually exclusive on buf_vld_ff
        if (accept) begin
            buf_nxt     = data_i;
            buf_vld_nxt = 1'b1;
        end

        if (load) begin
            sh_nxt      = buf_ff;
            cnt_nxt     = '0;
            state_nxt   = SHIFT;
            buf_vld_nxt = 1'b0;
        end else if (last_strobe) begin
            sh_nxt    = '0;
            cnt_nxt   = '0;
            state_nxt = IDLE;
        end else if ((state_ff == SHIFT) && bit_en_i) begin
            cnt_nxt = cnt_ff + 1'b1;
            if (MSB_FIRST)
                sh_nxt = {sh_ff[WIDTH-2:0], 1'b0};
            else
                sh_nxt = {1'b0, sh_ff[WIDTH-1:1]};
        end
    end

    assign ready_o   = !buf_vld_ff;
    assign x_valid_o = (state_ff == SHIFT);
    assign x_o       = x_valid_o && (MSB_FIRST ? sh_ff[WIDTH-1] : sh_ff[0]);
    assign last_o    = x_valid_o && (cnt_ff == CNT_LAST);
    assign busy_o    = x_valid_o || buf_vld_ff;

endmodule

// File: tb/tb_parallel_serializer.sv
// Directed bench for parallel_serializer: MSB-first and LSB-first instances
// share one stimulus stream; outputs are sampled on the falling edge.
module tb_parallel_serializer;

    logic       clk;
    logic       reset;
    logic [3:0] data;
    logic       valid;
    logic       bit_en;

    logic ready, x, xv, last, busy;
    logic ready_l, x_l, xv_l, last_l, busy_l;

    int n_cmp;
    int n_err;

    parallel_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) dut (
        .clk       (clk),
        .reset     (reset),
        .data_i    (data),
        .valid_i   (valid),
        .ready_o   (ready),
        .bit_en_i  (bit_en),
        .x_o       (x),
        .x_valid_o (xv),
        .last_o    (last),
        .busy_o    (busy)
    );

    parallel_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_l (
        .clk       (clk),
        .reset     (reset),
        .data_i    (data),
        .valid_i   (valid),
        .ready_o   (ready_l),
        .bit_en_i  (bit_en),
        .x_o       (x_l),
        .x_valid_o (xv_l),
        .last_o    (last_l),
        .busy_o    (busy_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [3:0]  e4;
        logic [3:0]  el;
        logic [7:0]  e8;
        logic [11:0] e12;
        logic        acc;

        n_cmp  = 0;
        n_err  = 0;
        reset  = 1'b0;
        data   = '0;
        valid  = 1'b0;
        bit_en = 1'b0;

        // reset values
        @(negedge clk);
        @(negedge clk);
        chk("rst_x", x, 0);
        chk("rst_xv", xv, 0);
        chk("rst_last", last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", ready, 1);
        reset = 1'b1;
        step();

        // single word, both bit orders
        e4 = 4'b1011;
        el = 4'b1101;
        valid = 1'b1; data = 4'hB; bit_en = 1'b1;
        step();
        valid = 1'b0;
        chk("sw_busy", busy, 1);
        chk("sw_xv0", xv, 0);
        step();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("sw_x%0d", i), x, e4[3-i]);
            chk($sformatf("sw_xv%0d", i), xv, 1);
            chk($sformatf("sw_last%0d", i), last, i == 3);
            chk($sformatf("lsb_x%0d", i), x_l, el[3-i]);
            chk($sformatf("lsb_last%0d", i), last_l, i == 3);
            step();
        end
        chk("sw_end_xv", xv, 0);
        chk("sw_end_x", x, 0);
        chk("sw_end_busy", busy, 0);
        chk("lsb_end_xv", xv_l, 0);

        // back-to-back B then 5
        e8 = 8'b1011_0101;
        valid = 1'b1; data = 4'hB; bit_en = 1'b1;
        step();
        chk("b2b_full", ready, 0);
        step();
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("b2b_x%0d", i), x, e8[7-i]);
            chk($sformatf("b2b_xv%0d", i), xv, 1);
            chk($sformatf("b2b_last%0d", i), last, (i == 3) || (i == 7));
            if (i == 0) begin
                chk("b2b_rdy_up", ready, 1);
                data = 4'h5;
            end
            if (i == 1) begin
                chk("b2b_rdy_dn", ready, 0);
                valid = 1'b0;
            end
            step();
        end
        chk("b2b_end_xv", xv, 0);
        chk("b2b_end_busy", busy, 0);

        // backpressure: 9, 3, E with strobes held off
        e12 = 12'b1001_0011_1110;
        valid = 1'b1; data = 4'h9; bit_en = 1'b0;
        step();
        step();
        chk("bp_rdy1", ready, 1);
        chk("bp_x_first", x, 1);
        data = 4'h3;
        step();
        data = 4'hE;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("bp_hold_rdy%0d", k), ready, 0);
            chk($sformatf("bp_hold_x%0d", k), x, 1);
            chk($sformatf("bp_hold_xv%0d", k), xv, 1);
            step();
        end
        bit_en = 1'b1;
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("bp_x%0d", i), x, e12[11-i]);
            chk($sformatf("bp_xv%0d", i), xv, 1);
            chk($sformatf("bp_last%0d", i), last,
                (i == 3) || (i == 7) || (i == 11));
            acc = valid && ready;
            step();
            if (acc) valid = 1'b0;
        end
        chk("bp_end_xv", xv, 0);
        chk("bp_end_busy", busy, 0);
        chk("bp_end_valid", valid, 0);

        // strobe gating: 6 with a strobe every third cycle
        e4 = 4'b0110;
        valid = 1'b1; data = 4'h6; bit_en = 1'b0;
        step();
        valid = 1'b0;
        step();
        for (int b = 0; b < 4; b++) begin
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("sg_x%0d_%0d", b, k), x, e4[3-b]);
                chk($sformatf("sg_xv%0d_%0d", b, k), xv, 1);
                chk($sformatf("sg_last%0d_%0d", b, k), last, b == 3);
                bit_en = (k == 2);
                step();
            end
        end
        bit_en = 1'b0;
        chk("sg_end_xv", xv, 0);

        // reset mid-word with a buffered word
        valid = 1'b1; data = 4'hB; bit_en = 1'b1;
        step();
        step();
        chk("rm_x0", x, 1);
        data = 4'h5;
        step();
        valid = 1'b0;
        chk("rm_buf_full", ready, 0);
        step();
        chk("rm_x2", x, 1);
        chk("rm_busy", busy, 1);
        reset = 1'b0;
        #1;
        chk("rm_xv", xv, 0);
        chk("rm_x", x, 0);
        chk("rm_busy0", busy, 0);
        chk("rm_ready", ready, 1);
        chk("rm_lsb_xv", xv_l, 0);
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            chk($sformatf("rm_idle_xv%0d", k), xv, 0);
            chk($sformatf("rm_idle_busy%0d", k), busy, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/parallel_serializer.md
# parallel_serializer

Parallel-to-serial transmitter that sits directly upstream of the 4-bit serial-in shift register and drives its serial input. It accepts parallel words over a valid/ready handshake and holds one word in a buffer while another is being shifted. Each word is shifted out one bit per `bit_en_i` strobe. It also emits a per-bit valid and an end-of-word marker, so the downstream stage can clock-enable its shift on `x_valid_o && bit_en_i`.

## Interface
- `WIDTH`, default 4: word width in bits. Legal values are 2 and above.
- `MSB_FIRST`, default 1: 1 sends the MSB first, 0 sends the LSB first.
- `clk`, input, 1 bit: the single clock. Everything is rising-edge.
- `reset`, input, 1 bit: asynchronous, active-low reset. Low clears all state immediately.
- `data_i`, input, WIDTH bits: parallel word to send.
- `valid_i`, input, 1 bit: `data_i` is valid.
- `ready_o`, output, 1 bit: the block can accept a word this cycle.
- `bit_en_i`, input, 1 bit: bit strobe. The current bit is consumed at a rising edge where this is 1.
- `x_o`, output, 1 bit: serial data, feeding the downstream `x_i`.
- `x_valid_o`, output, 1 bit: `x_o` carries a valid bit.
- `last_o`, output, 1 bit: the current bit is the final bit of its word.
- `busy_o`, output, 1 bit: the shifter or the buffer holds data.

## Operation
- Storage:
  - `buf_ff` / `buf_vld_ff`: one-word input buffer.
  - `sh_ff`: WIDTH-bit shifter.
  - `cnt_ff`: bit counter, `$clog2(WIDTH)` bits wide, counting 0..WIDTH-1.
  - `state_ff`: IDLE or SHIFT.
- Handshake:
  - `ready_o = !buf_vld_ff`, purely registered-state driven with no combinational path from `valid_i`.
  - A word is accepted at any edge where `valid_i && ready_o`; it is written into `buf_ff` and `buf_vld_ff` is set.
  - `data_i` is don't-care when `valid_i` is 0.
  - The word must stay stable while `valid_i && !ready_o`.
- Load condition, `load`:
  - `buf_vld_ff && (state==IDLE || (state==SHIFT && bit_en_i && cnt_ff==WIDTH-1))`.
  - On load: `sh_ff` ← `buf_ff`, `cnt_ff` ← 0, state → SHIFT, `buf_vld_ff` cleared.
  - Accept and load never coincide, because accept needs the buffer empty and load needs it full.
- FSM:
  - IDLE → SHIFT on `load`.
  - SHIFT + `bit_en_i` + `cnt_ff==WIDTH-1` + no buffered word → IDLE. `sh_ff` and `cnt_ff` clear to 0.
  - SHIFT + `bit_en_i` + `cnt_ff<WIDTH-1`:
    - `cnt_ff` increments.
    - `sh_ff` shifts left with 0 fill when `MSB_FIRST=1`, right with 0 fill when `MSB_FIRST=0`.
  - SHIFT with `bit_en_i`=0: hold everything.
- Outputs:
  - `x_o = x_valid_o ? (MSB_FIRST ? sh_ff[WIDTH-1] : sh_ff[0]) : 0`.
  - `x_valid_o = (state==SHIFT)`.
  - `last_o = x_valid_o && cnt_ff==WIDTH-1`.
  - `busy_o = x_valid_o || buf_vld_ff`.
- Reset values:
  - State IDLE; `sh_ff`, `cnt_ff`, `buf_ff` are 0; `buf_vld_ff` is 0.
  - Outputs: `x_o`=0, `x_valid_o`=0, `last_o`=0, `busy_o`=0, `ready_o`=1.
- Reset asserted mid-word discards both the in-flight word and the buffered word. No partial word resumes after reset.
- `bit_en_i` pulses are ignored in IDLE.
- `bit_en_i` held high streams one bit per cycle.

## Timing
- Accept at edge E0: `busy_o` goes high after E0.
  - From IDLE, the load happens at E1.
  - The first bit is on `x_o`, with `x_valid_o`=1, from E1 onward.
  - Fastest `valid_i`-to-first-bit latency: 2 edges.
- Each bit stays on `x_o` until the edge where `bit_en_i`=1. The downstream stage samples the bit at that same edge.
- Back-to-back streaming has zero gap cycles when a word is buffered before the final-bit strobe of the current word.
  - The next word's first bit appears the cycle right after the last bit of the previous word.
  - `ready_o` rises the cycle after each load.
- With `bit_en_i` tied to 1 and `valid_i` tied to 1, sustained throughput is 1 bit per cycle and one word every WIDTH cycles.
- The buffer is written only when it is empty, so no data is lost and a full buffer means `ready_o`=0.

## Test plan
- **Single word.** Reset, then `WIDTH`=4, `MSB_FIRST`=1, `bit_en_i`=1, send 4'hB once.
  - `x_o` = 1,0,1,1 on 4 consecutive cycles, starting 2 edges after the accept.
  - `x_valid_o` is high for exactly 4 cycles; `last_o` is high on the 4th bit only.
  - Block returns to IDLE with `x_o`=0 and `busy_o`=0.
- **Back-to-back.** Send 4'hB then 4'h5 with `valid_i` held high.
  - 8 contiguous valid bits 1,0,1,1,0,1,0,1.
  - `last_o` on bits 4 and 8.
  - `ready_o` low while the buffer is full.
- **Backpressure.** Present 3 words with `bit_en_i`=0 after the first load.
  - The 2nd word is accepted; `ready_o` then stays 0 and the 3rd word is held.
  - `x_o` stays at the first bit of the first word.
  - Enabling `bit_en_i` drains all 3 words in order with no loss or duplication.
- **Strobe gating.** `bit_en_i` pulses every 3rd cycle while sending 4'h6.
  - Each bit is held for 3 cycles; bits are 0,1,1,0.
  - The counter advances only on strobes.
- **LSB-first.** `MSB_FIRST`=0, send 4'hB → `x_o` = 1,1,0,1.
- **Reset mid-word.** Assert `reset` low after 2 bits of 4'hB, with a buffered 4'h5 present.
  - Immediately: `x_valid_o`=0, `x_o`=0, `busy_o`=0, `ready_o`=1.
  - After release, nothing is transmitted until a new word is accepted.
